// File: rtl/nn_seq_pkg.sv
// Shared types and helpers for the inference-core batch sequencer.
package nn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_EMIT,
    S_DONE
  } state_t;

  // Fixed-point 1.0 for a given number of fractional bits.
  function automatic int one_q(input int nfrac);
    return 1 << nfrac;
  endfunction

  function automatic logic clamp_neg(input logic sign_bit, input logic enable);
    return sign_bit & enable;
  endfunction

endpackage

// File: rtl/nn_seq_result_clamp.sv
// Combinational clamp of a result vector: negative elements become 1.0
// when enabled; also reports how many elements were replaced.
module nn_seq_result_clamp
  import nn_seq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NFRAC       = 10,
  parameter int OUTPUT_SIZE = 5,
  parameter int CLAMP_NEG   = 1
) (
  input  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]     data_in,
  output logic [OUTPUT_SIZE-1:0][WIDTH-1:0]     data_out,
  output logic [$clog2(OUTPUT_SIZE+1)-1:0]      n_clamped
);

  localparam int NW = $clog2(OUTPUT_SIZE+1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(one_q(NFRAC));

  logic [OUTPUT_SIZE-1:0] hit;

  for (genvar i = 0; i < OUTPUT_SIZE; i++) begin : g_lane
    assign hit[i]      = clamp_neg(data_in[i][WIDTH-1], CLAMP_NEG != 0);
    assign data_out[i] = hit[i] ? ONE : data_in[i];
  end

  always_comb begin
    n_clamped = '0;
    for (int i = 0; i < OUTPUT_SIZE; i++) n_clamped = n_clamped + NW'(hit[i]);
  end

endmodule

// File: rtl/nn_batch_sequencer.sv
// Batch driver for a single-shot inference core: fetch, issue, wait for the
// core, settle, clamp and emit each result, with watchdog and abort.
module nn_batch_sequencer
  import nn_seq_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int NFRAC          = 10,
  parameter int INPUT_SIZE     = 16,
  parameter int OUTPUT_SIZE    = 5,
  parameter int MAX_VECTORS    = 65535,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CLAMP_NEG      = 1,
  parameter int CW             = $clog2(MAX_VECTORS+1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [CW-1:0]                        num_vectors,
  input  logic                                 vec_valid,
  output logic                                 vec_ready,
  input  logic [INPUT_SIZE-1:0][WIDTH-1:0]     vec_data,
  output logic                                 core_input_ready,
  output logic [INPUT_SIZE-1:0][WIDTH-1:0]     core_input_data,
  input  logic                                 core_output_ready,
  input  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]    core_output_data,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [OUTPUT_SIZE-1:0][WIDTH-1:0]    res_data,
  output logic [CW-1:0]                        res_index,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 timeout_err,
  output logic [31:0]                          clamp_count
);

  localparam int NW = $clog2(OUTPUT_SIZE+1);
  localparam int SW = $clog2(SETTLE_CYCLES+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);

  state_t state, state_nxt;

  logic [CW-1:0] count_q;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] wd_cnt;
  logic          out_rdy_q;
  logic          out_edge, wd_expire, settle_last, last_vec, accept_start, capture;
  logic [OUTPUT_SIZE-1:0][WIDTH-1:0] clamped;
  logic [NW-1:0] n_clamped;
  logic [32:0]   clamp_sum;

  nn_seq_result_clamp #(
    .WIDTH(WIDTH), .NFRAC(NFRAC), .OUTPUT_SIZE(OUTPUT_SIZE), .CLAMP_NEG(CLAMP_NEG)
  ) u_clamp (
    .data_in(core_output_data),
    .data_out(clamped),
    .n_clamped(n_clamped)
  );

  // A level already high when WAIT begins is stale; only a fresh rise counts.
  assign out_edge     = core_output_ready && !out_rdy_q;
  assign wd_expire    = wd_cnt == TW'(TIMEOUT_CYCLES-1);
  assign settle_last  = settle_cnt == '0;
  assign last_vec     = res_index == count_q - 1'b1;
  assign accept_start = state == S_IDLE && start && num_vectors != '0;
  assign capture      = state == S_SETTLE && settle_last && !abort;
  assign clamp_sum    = {1'b0, clamp_count} + 33'(n_clamped);

  always_comb begin
    state_nxt        = state;
    vec_ready        = 1'b0;
    core_input_ready = 1'b0;
    res_valid        = 1'b0;
    done             = 1'b0;
    busy             = state != S_IDLE;
    unique case (state)
      S_IDLE:   if (start) state_nxt = (num_vectors != '0) ? S_FETCH : S_DONE;
      S_FETCH: begin
        vec_ready = 1'b1;
        if (vec_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        core_input_ready = 1'b1;
        state_nxt        = S_WAIT;
      end
      S_WAIT: begin
        if (out_edge)       state_nxt = S_SETTLE;
        else if (wd_expire) state_nxt = S_DONE;
      end
      S_SETTLE: if (settle_last) state_nxt = S_EMIT;
      S_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = last_vec ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE && state != S_DONE) state_nxt = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      count_q         <= '0;
      settle_cnt      <= '0;
      wd_cnt          <= '0;
      out_rdy_q       <= 1'b0;
      core_input_data <= '0;
      res_data        <= '0;
      res_index       <= '0;
      timeout_err     <= 1'b0;
      clamp_count     <= '0;
    end else begin
      state     <= state_nxt;
      out_rdy_q <= core_output_ready;

      if (accept_start) begin
        count_q     <= num_vectors;
        res_index   <= '0;
        timeout_err <= 1'b0;
        clamp_count <= '0;
      end

      if (state == S_FETCH && vec_valid) core_input_data <= vec_data;

      if (state == S_ISSUE)     wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 1'b1;

      if (state == S_WAIT && !out_edge && wd_expire) timeout_err <= 1'b1;

      if (state == S_WAIT && out_edge)
        settle_cnt <= SW'(SETTLE_CYCLES-1);
      else if (state == S_SETTLE && !settle_last)
        settle_cnt <= settle_cnt - 1'b1;

      if (capture) begin
        res_data    <= clamped;
        clamp_count <= clamp_sum[32] ? '1 : clamp_sum[31:0];
      end

      if (state == S_EMIT && res_ready && !abort && !last_vec)
        res_index <= res_index + 1'b1;
    end
  end

endmodule
